// File: rtl/lca_chunk_sequencer.sv
// ----------------------------------------------------------------------------
// lca_chunk_sequencer
//   Multi-cycle wide-add controller for a WIDTH-bit lookahead carry adder.
//   It accepts two TW-bit operands (TW = WIDTH*CHUNKS) and a carry-in over a
//   valid/ready handshake. It then sends one WIDTH-bit chunk per cycle to the
//   external adder, starting with the LSB chunk. The carry is registered
//   between chunks. When all chunks are done, it presents the assembled sum and
//   carry-out on a valid/ready output.
//
//   The adder is combinational. It sits outside this block: add_a/add_b/add_cin
//   go out, and add_s/add_cout come back in the same cycle.
//
//   Optional feature macro: OVERFLOW_DET_EN
//     When defined, the block adds an out_ovf port. It flags two's-complement
//     signed overflow of the full TW-bit add and is registered alongside
//     out_cout.
// ----------------------------------------------------------------------------
module lca_chunk_sequencer #(
  parameter int WIDTH  = 4,
  parameter int CHUNKS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*CHUNKS-1:0]   in_a,
  input  logic [WIDTH*CHUNKS-1:0]   in_b,
  input  logic                      in_cin,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  output logic                      add_cin,
  input  logic [WIDTH-1:0]          add_s,
  input  logic                      add_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*CHUNKS-1:0]   out_sum,
  output logic                      out_cout
`ifdef OVERFLOW_DET_EN
  ,
  output logic                      out_ovf
`endif
);

  localparam int TW    = WIDTH * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [TW-1:0]    a_q;
  logic [TW-1:0]    b_q;
  logic [TW-1:0]    sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;

  logic             accept;
  logic             running;
  logic             last_chunk;
  logic             deliver;

`ifdef OVERFLOW_DET_EN
  logic             ovf_q;
  logic             ovf_next;
`endif

  // Return chunk i of a TW-bit operand. Callers use this only while idx is in range.
  function automatic logic [WIDTH-1:0] get_chunk(input logic [TW-1:0]    v,
                                                 input logic [IDX_W-1:0] i);
    return v[int'(i)*WIDTH +: WIDTH];
  endfunction

  // Signed overflow: the operand signs agree, but the result sign differs.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign accept     = (state_q == IDLE) && in_valid;
  assign running    = (state_q == RUN);
  assign last_chunk = running && (idx_q == LAST_IDX);
  assign deliver    = (state_q == DONE) && out_ready;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last chunk,
  // DONE -> IDLE once the result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (deliver)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output decode. The adder ports are driven only in RUN and stay zero otherwise.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = get_chunk(a_q, idx_q);
        add_b   = get_chunk(b_q, idx_q);
        add_cin = carry_q;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  // Chunk index and inter-chunk carry.
  // The index returns to zero after the last chunk, so it never points past
  // the operand when CHUNKS is not a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= in_cin;
    end else if (running) begin
      carry_q <= add_cout;
      idx_q   <= last_chunk ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Result assembly: each RUN cycle writes one sum chunk.
  // In DONE nothing is written, so the result holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (running) begin
      sum_q[int'(idx_q)*WIDTH +: WIDTH] <= add_s;
    end
  end

  // Carry-out of the full add, taken from the MSB chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
    end else if (last_chunk) begin
      cout_q <= add_cout;
    end
  end

`ifdef OVERFLOW_DET_EN
  // On the last chunk, add_s holds the MSB chunk of the sum, so its top bit is the result sign.
  assign ovf_next = signed_ovf(a_q[TW-1], b_q[TW-1], add_s[WIDTH-1]);

  // Overflow flag, registered together with the carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_chunk) begin
      ovf_q <= ovf_next;
    end
  end

  assign out_ovf = ovf_q;
`endif

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_lca_chunk_sequencer.sv
// ----------------------------------------------------------------------------
// tb_lca_chunk_sequencer
//   Bench for lca_chunk_sequencer with a behavioural adder attached.
//   Directed cases cover:
//     - reset values
//     - a plain add and a full carry ripple
//     - backpressure hold
//     - abort by reset in the middle of RUN
//     - signed overflow (only when OVERFLOW_DET_EN is defined)
//   A randomized run follows. Its results are scored against a + b + cin
//   computed at full width, and its opening back-to-back phase checks the
//   accept period.
// ----------------------------------------------------------------------------
module tb_lca_chunk_sequencer;

  localparam int WIDTH  = 4;
  localparam int CHUNKS = 4;
  localparam int TW     = WIDTH * CHUNKS;
  localparam int NOPS   = 1000;
  localparam int B2B    = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [TW-1:0]     in_a;
  logic [TW-1:0]     in_b;
  logic              in_cin;
  logic [WIDTH-1:0]  add_a;
  logic [WIDTH-1:0]  add_b;
  logic              add_cin;
  logic [WIDTH-1:0]  add_s;
  logic              add_cout;
  logic              out_valid;
  logic              out_ready;
  logic [TW-1:0]     out_sum;
  logic              out_cout;
`ifdef OVERFLOW_DET_EN
  logic              out_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [TW+1:0] exp_q[$];   // {ovf, cout, sum}
  logic          drv_done = 1'b0;
  logic          b2b      = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural combinational adder: the chunk adder the sequencer drives.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);

  lca_chunk_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef OVERFLOW_DET_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result for the full add: {ovf, cout, sum}.
  function automatic logic [TW+1:0] ref_add(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                            input logic cin);
    logic [TW:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
    ovf  = (a[TW-1] == b[TW-1]) && (full[TW-1] != a[TW-1]);
    return {ovf, full};
  endfunction

  // Carry entering chunk c: the carry out of the low c*WIDTH bits plus cin.
  function automatic logic carry_into(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                      input logic cin, input int c);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << (c * WIDTH)) - 64'd1;
    s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return s[c * WIDTH];
  endfunction

  // One directed operation. Entry and exit are #1 after a rising edge, in IDLE.
  task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                        input int hold);
    logic [TW+1:0] e;
    logic [63:0]   mask;
    e    = ref_add(a, b, cin);
    mask = (64'd1 << WIDTH) - 64'd1;
    check_eq("in_ready_idle", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < CHUNKS; c++) begin
      check_eq("in_ready_run", 64'(in_ready), 64'd0);
      check_eq("out_valid_run", 64'(out_valid), 64'd0);
      check_eq("add_a_chunk", 64'(add_a), (64'(a) >> (c * WIDTH)) & mask);
      check_eq("add_b_chunk", 64'(add_b), (64'(b) >> (c * WIDTH)) & mask);
      check_eq("add_cin_chunk", 64'(add_cin), 64'(carry_into(a, b, cin, c)));
      @(posedge clk); #1;
    end
    check_eq("out_valid_latency", 64'(out_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_sum", 64'(out_sum), 64'(e[TW-1:0]));
      check_eq("hold_cout", 64'(out_cout), 64'(e[TW]));
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    check_eq("out_sum", 64'(out_sum), 64'(e[TW-1:0]));
    check_eq("out_cout", 64'(out_cout), 64'(e[TW]));
`ifdef OVERFLOW_DET_EN
    check_eq("out_ovf", 64'(out_ovf), 64'(e[TW+1]));
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("out_valid_after_take", 64'(out_valid), 64'd0);
    check_eq("in_ready_after_take", 64'(in_ready), 64'd1);
    check_eq("add_a_idle", 64'(add_a), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    check_eq({tag, "_out_cout"}, 64'(out_cout), 64'd0);
    check_eq({tag, "_add_a"}, 64'(add_a), 64'd0);
    check_eq({tag, "_add_b"}, 64'(add_b), 64'd0);
    check_eq({tag, "_add_cin"}, 64'(add_cin), 64'd0);
`ifdef OVERFLOW_DET_EN
    check_eq({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
`endif
  endtask

  task automatic drive_all();
    int prev_acc;
    prev_acc = 0;
    for (int i = 0; i < NOPS; i++) begin
      logic [TW-1:0] a;
      logic [TW-1:0] b;
      logic          c;
      int            waited;
      b2b = (i < B2B);
      if (!b2b && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      a = TW'($urandom);
      b = TW'($urandom);
      c = 1'($urandom);
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check_eq("accept_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
        drv_done = 1'b1;
        return;
      end
      exp_q.push_back(ref_add(a, b, c));
      if (i > 0 && i < B2B) check_eq("b2b_period", 64'(cyc - prev_acc), 64'(CHUNKS + 2));
      prev_acc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    drv_done = 1'b1;
  endtask

  task automatic monitor_all();
    int            guard;
    logic [TW+1:0] e;
    guard = 0;
    while (!(drv_done && exp_q.size() == 0) && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
      out_ready = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rnd_sum", 64'(out_sum), 64'(e[TW-1:0]));
          check_eq("rnd_cout", 64'(out_cout), 64'(e[TW]));
`ifdef OVERFLOW_DET_EN
          check_eq("rnd_ovf", 64'(out_ovf), 64'(e[TW+1]));
`endif
        end
      end
    end
    check_eq("rnd_drained", 64'(drv_done && exp_q.size() == 0), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain add, no inter-chunk carries.
    run_op(16'h1234, 16'h1111, 1'b0, 0);
    // Carry ripples through every chunk.
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    // Result held under 10 cycles of backpressure.
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 10);
    // out_ready high while idle has no effect.
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_ready_no_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Reset in the third RUN cycle aborts the operation.
    in_a = 16'hABCD; in_b = 16'h1357; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < CHUNKS + 2; k++) begin
      check_eq("abort_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0);

`ifdef OVERFLOW_DET_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 0);
`endif

    fork
      drive_all();
      monitor_all();
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
